tv_stream_gen: RTL and testbench

Video timing transmitter that regenerates the decoder-side pixel stream (tv_x, tv_y, tv_field, tv_dval, data, tv_count) from a linear pixel source. It drains a first-word-fall-through pixel FIFO and paces pixels at one slot per CLK_DIV clocks. It drives a field-interlaced raster with blanking, so the linearising address stage and everything downstream can run from stored or synthetic frames without a live decoder. It sits in place of the video decoder output in the capture path, for playback and bench loopback.

---
 rtl/tv_stream_gen.sv | 111 +++++++++++
 tb/tb_tv_stream_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tv_stream_gen.sv
// Field-interlaced video timing transmitter: drains a FWFT pixel FIFO at one
// slot per CLK_DIV clocks and regenerates the decoder-side raster stream.
`timescale 1ns/1ps
module tv_stream_gen #(
  parameter int H_ACTIVE = 720,
  parameter int H_TOTAL  = 858,
  parameter int V_ACTIVE = 288,
  parameter int V_TOTAL  = 312,
  parameter int CLK_DIV  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_pop,
  output logic [9:0]  tv_x,
  output logic [9:0]  tv_y,
  output logic        tv_field,
  output logic        tv_dval,
  output logic [15:0] data,
  output logic [31:0] tv_count,
  output logic        underrun,
  output logic        busy
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT  = 10'(V_ACTIVE);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [DIV_W-1:0] div;
  logic             step;
  logic             active_nxt;
  logic             wrap_nxt;
  logic [9:0]       x_nxt, y_nxt;
  logic             field_nxt;

  // Position the raster moves to on the coming step.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    x_nxt     = tv_x + 10'd1;
    y_nxt     = tv_y;
    field_nxt = tv_field;
    if (tv_x == X_LAST) begin
      x_nxt = 10'd0;
      if (tv_y == Y_LAST) begin
        y_nxt     = 10'd0;
        field_nxt = ~tv_field;
      end else begin
        y_nxt = tv_y + 10'd1;
      end
    end
  end

  assign step       = (state == S_RUN) && (div == DIV_LAST);
  assign active_nxt = (x_nxt >= 10'd1) && (x_nxt <= X_ACT) &&
                      (y_nxt >= 10'd1) && (y_nxt <= Y_ACT);
  assign wrap_nxt   = (x_nxt == 10'd0) && (y_nxt == 10'd0) && !field_nxt;
  assign pix_pop    = step && active_nxt && pix_valid;

  // Leaving RUN only on the frame-closing wrap keeps every frame complete.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (en) state_nxt = S_RUN;
      S_RUN:   if (step && wrap_nxt && !en) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      div      <= '0;
      tv_x     <= 10'd0;
      tv_y     <= 10'd0;
      tv_field <= 1'b0;
      tv_dval  <= 1'b0;
      data     <= 16'd0;
      tv_count <= 32'd0;
      underrun <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state    <= state_nxt;
      busy     <= (state_nxt == S_RUN);
      if (state == S_RUN)
        div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      else
        div <= '0;
      tv_dval  <= step && active_nxt;
      underrun <= step && active_nxt && !pix_valid;
      if (step) begin
        tv_x     <= x_nxt;
        tv_y     <= y_nxt;
        tv_field <= field_nxt;
        tv_count <= tv_count + 32'd1;
        if (active_nxt)
          data <= pix_valid ? pix_data : 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_tv_stream_gen.sv
// Directed bench for tv_stream_gen on a tiny 6x3 raster (4x2 active, CLK_DIV=2).
`timescale 1ns/1ps
module tb_tv_stream_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_pop;
  logic [9:0]  tv_x, tv_y;
  logic        tv_field, tv_dval;
  logic [15:0] data;
  logic [31:0] tv_count;
  logic        underrun, busy;

  tv_stream_gen #(
    .H_ACTIVE(4), .H_TOTAL(6), .V_ACTIVE(2), .V_TOTAL(3), .CLK_DIV(2)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_pop(pix_pop),
    .tv_x(tv_x), .tv_y(tv_y), .tv_field(tv_field), .tv_dval(tv_dval),
    .data(data), .tv_count(tv_count), .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // FWFT FIFO model; rd_ptr doubles as the running pop count.
  logic [15:0] fifo_mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        starve = 1'b0;
  int          cyc = 0;

  assign pix_valid = (rd_ptr != wr_ptr) && !starve;
  assign pix_data  = fifo_mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pix_pop) rd_ptr <= rd_ptr + 1;
  end

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        f;
    logic [15:0] d;
  } dval_vec_t;

  dval_vec_t frame_tbl [16];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [15:0] w);
    fifo_mem[wr_ptr[5:0]] = w;
    wr_ptr++;
  endtask

  // Waits (bounded) for the next step, detected by tv_count moving.
  task automatic next_step();
    logic [31:0] prev;
    int n;
    prev = tv_count;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tv_count == prev && n < 8);
    if (tv_count == prev) check("step_timeout", tv_count, prev + 32'd1);
  endtask

  initial begin
    int k, last_cyc, s, pops_before;
    logic [15:0] exp_word;
    logic stopped;

    // Expected dval slots: field 0 then 1, lines 1..2, x 1..4, data 1..16.
    k = 0;
    for (int f = 0; f < 2; f++)
      for (int y = 1; y <= 2; y++)
        for (int x = 1; x <= 4; x++) begin
          frame_tbl[k].x = 10'(x);
          frame_tbl[k].y = 10'(y);
          frame_tbl[k].f = f[0];
          frame_tbl[k].d = 16'(k + 1);
          k++;
        end

    reset = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pos",   {11'd0, tv_field, tv_y, tv_x}, 32'd0);
    check("rst_count", tv_count, 32'd0);
    check("rst_flags", {28'd0, tv_dval, underrun, busy, pix_pop}, 32'd0);

    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy",  {31'd0, busy}, 32'd0);
    check("idle_count", tv_count, 32'd0);

    // Full frame.
    for (int i = 1; i <= 16; i++) push(16'(i));
    en = 1'b1;
    k = 0;
    last_cyc = 0;
    for (s = 0; s < 36; s++) begin
      next_step();
      if (tv_dval) begin
        if (k < 16) begin
          check("frame_pos", {11'd0, tv_field, tv_y, tv_x},
                {11'd0, frame_tbl[k].f, frame_tbl[k].y, frame_tbl[k].x});
          check("frame_data", {16'd0, data}, {16'd0, frame_tbl[k].d});
          if (k > 0 && frame_tbl[k].y == frame_tbl[k-1].y && frame_tbl[k].f == frame_tbl[k-1].f)
            check("dval_spacing", cyc - last_cyc, 32'd2);
        end
        last_cyc = cyc;
        k++;
        @(negedge clk);
        check("dval_width", {31'd0, tv_dval}, 32'd0);
      end
    end
    check("frame_dvals", k, 32'd16);
    check("frame_pops",  rd_ptr, 32'd16);
    check("frame_count", tv_count, 32'd36);
    check("frame_end_pos", {11'd0, tv_field, tv_y, tv_x}, 32'd0);

    // Wrap with en still high: (0,0,0) -> (1,0,0), no dval.
    next_step();
    check("wrap_pos",   {11'd0, tv_field, tv_y, tv_x}, {11'd0, 1'b0, 10'd0, 10'd1});
    check("wrap_dval",  {31'd0, tv_dval}, 32'd0);
    check("wrap_count", tv_count, 32'd37);

    // Underrun at (3,1,0) and en dropped at (2,1,0); raster finishes field 1.
    for (int i = 0; i < 20; i++) push(16'h0011 + 16'(i));
    exp_word = 16'h0011;
    stopped = 1'b0;
    pops_before = 0;
    for (s = 0; s < 60; s++) begin
      next_step();
      if (starve) begin
        check("under_pos",   {11'd0, tv_field, tv_y, tv_x}, {11'd0, 1'b0, 10'd1, 10'd3});
        check("under_dval",  {31'd0, tv_dval}, 32'd1);
        check("under_data",  {16'd0, data}, 32'd0);
        check("under_flag",  {31'd0, underrun}, 32'd1);
        check("under_nopop", rd_ptr, pops_before);
        check("busy_after_en_drop", {31'd0, busy}, 32'd1);
        starve = 1'b0;
        @(negedge clk);
        check("under_pulse", {31'd0, underrun}, 32'd0);
      end else if (tv_dval) begin
        check("stream_data", {16'd0, data}, {16'd0, exp_word});
        exp_word++;
      end
      if (!stopped && tv_x == 10'd2 && tv_y == 10'd1 && !tv_field) begin
        en = 1'b0;
        starve = 1'b1;
        stopped = 1'b1;
        pops_before = rd_ptr;
      end
      if (tv_x == 10'd0 && tv_y == 10'd0 && !tv_field) break;
    end
    check("stop_count", tv_count, 32'd72);
    check("stop_words", {16'd0, exp_word}, 32'h0020);
    check("stop_pops",  rd_ptr, 32'd31);
    repeat (2) @(negedge clk);
    check("stop_busy", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
    check("idle_no_pop",   rd_ptr, 32'd31);
    check("idle_hold_cnt", tv_count, 32'd72);
    check("idle_hold_pos", {11'd0, tv_field, tv_y, tv_x}, 32'd0);

    // Restart: first step two clocks after entering RUN, count continues.
    en = 1'b1;
    @(negedge clk);
    check("restart_busy",  {31'd0, busy}, 32'd1);
    check("restart_cnt0",  tv_count, 32'd72);
    @(negedge clk);
    check("restart_cnt1",  tv_count, 32'd72);
    @(negedge clk);
    check("restart_first", tv_count, 32'd73);
    check("restart_pos",   {11'd0, tv_field, tv_y, tv_x}, {11'd0, 1'b0, 10'd0, 10'd1});

    // Run to the first active slot, then reset asynchronously mid-cycle.
    for (s = 0; s < 10 && !tv_dval; s++) next_step();
    check("restart_data", {16'd0, data}, 32'h0020);
    check("restart_pops", rd_ptr, 32'd32);
    #2 reset = 1'b0;
    #1;
    check("midrst_pos",   {11'd0, tv_field, tv_y, tv_x}, 32'd0);
    check("midrst_data",  {16'd0, data}, 32'd0);
    check("midrst_count", tv_count, 32'd0);
    check("midrst_flags", {28'd0, tv_dval, underrun, busy, pix_pop}, 32'd0);
    repeat (4) @(negedge clk);
    check("midrst_no_pop", rd_ptr, 32'd32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
